thumb_fetch_unit: RTL
=====================

# thumb_fetch_unit

Instruction fetch front end for the Thumb pipeline. It drives the instruction-memory request port (IREQ/IADDR/IRW/INSTR) and splits each returned 32-bit word into two 16-bit Thumb halfwords. The halfwords are buffered in a small prefetch queue and handed to decode through a valid/ready handshake, each tagged with its own address. Decode or execute can redirect fetch to a new PC, which flushes the queue and any in-flight word.

## Interface
- DEPTH, 4: halfword queue entries. Power of 2, at least 4.
- RESET_PC, 32'h0000_0000: fetch address after reset. Must be word-aligned.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- IREQ  out  1  instruction-memory request.
- IADDR  out  32  word-aligned fetch address; stable while IREQ=1.
- IRW  out  1  access type; constant 0 (read).
- INSTR  in  32  fetched word. Bits [15:0] are the halfword at IADDR+0; bits [31:16] are the halfword at IADDR+2.
- F_VALID  out  1  queue head holds a halfword.
- F_INST  out  16  queue-head halfword; 0 when F_VALID=0.
- F_PC  out  32  byte address of F_INST (bit 0 = 0); 0 when F_VALID=0.
- D_READY  in  1  decode accepts the head this cycle (handshake = F_VALID & D_READY).
- REDIRECT  in  1  one-cycle pulse: flush and restart fetch.
- REDIRECT_PC  in  32  target address. Bit 0 is ignored.

## Operation
- Memory protocol:
  - One request outstanding at most.
  - A request holds IREQ=1 with IADDR stable for exactly 2 cycles (states REQ1 then REQ2).
  - INSTR is sampled on the edge that ends REQ2.
- FSM states:
  - IDLE: IREQ=0.
  - IDLE -> REQ1 when the issue condition holds or REDIRECT=1.
  - REQ1 -> REQ2 always.
  - REQ2 -> REQ1 (back-to-back request) if the issue condition holds for the post-edge count, else IDLE.
- Issue condition: post-edge queue count ≤ DEPTH-2. This guarantees room for both halfwords of the next word.
- Internal registers:
  - fetch_pc: word address of the next request; +4 per issued request.
  - skip_lo: drop the low halfword of the next captured word.
  - squash: discard the in-flight word.
- Capture at end of REQ2 (when squash=0):
  - Push INSTR[15:0] tagged fetch addr+0, unless skip_lo is set.
  - Then push INSTR[31:16] tagged addr+2.
  - Clear skip_lo.
- Pop: one halfword per handshake. Push and pop may occur on the same edge; count moves by pushes minus pop.
- REDIRECT with FSM in IDLE:
  - Clear the queue.
  - fetch_pc <= {REDIRECT_PC[31:2],2'b00}; skip_lo <= REDIRECT_PC[1].
  - Go to REQ1 with IADDR = the new word address.
- REDIRECT with FSM in REQ1/REQ2:
  - Clear the queue; set squash; load fetch_pc and skip_lo as above.
  - The current request completes unchanged (IADDR not altered mid-request). Its data is discarded and squash is cleared.
  - The FSM then goes directly REQ2 -> REQ1 at the target.
- REDIRECT coincident with a handshake: redirect wins. The popped halfword counts as consumed and the queue is empty after the edge.
- REDIRECT coincident with a capture: the captured word is discarded.
- Reset values (any time, including mid-request): FSM=IDLE, IREQ=0, IADDR=RESET_PC, fetch_pc=RESET_PC, queue empty, F_VALID=0, F_INST=0, F_PC=0, skip_lo=0, squash=0. An in-flight word is abandoned.
- Arithmetic: all addresses are 32-bit and wrap modulo 2^32; fetch_pc 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset released before edge 1: IREQ=1 after edge 1 (IADDR=RESET_PC), REQ2 after edge 2, capture at edge 3. F_VALID=1 after edge 3.
- REDIRECT sampled at edge n with FSM idle: IREQ=1 after edge n; first halfword F_VALID=1 after edge n+2.
- REDIRECT sampled during a request: first new halfword arrives 2 cycles after the squashed request ends.
- Sustained bandwidth: 1 word per 2 cycles = 1 halfword/cycle. Decode at D_READY=1 never starves after the first capture.
- F_VALID/F_INST/F_PC are combinational from the queue head (registered storage); no input-to-output paths.

## Structure
- Package thumb_fetch_pkg:
  - FSM state enum (IDLE, REQ1, REQ2).
  - IRW_READ = 1'b0.
  - HW_BYTES = 2.
  - Queue entry type {pc[31:0], inst[15:0]}.
- Sub-module hw_queue: DEPTH-entry circular FIFO with 0/1/2 pushes and 0/1 pop per cycle, plus synchronous clear and a count output. The FSM and address logic stay in thumb_fetch_unit.

## Test plan
- Reset then stream with D_READY=1; memory returns 32'hBBBB_AAAA at address 0 and 32'hDDDD_CCCC at address 4. Decode must receive AAAA@0, BBBB@2, CCCC@4, DDDD@6 on consecutive cycles starting after edge 3.
- D_READY=0 held: queue fills to DEPTH=4 and no further IREQ rises. Then D_READY=1: fetch resumes, no halfword is lost or duplicated, and F_PC stays monotonic.
- REDIRECT_PC=32'h0000_0102 from IDLE: IADDR=32'h100 after the pulse edge. The first delivered halfword is INSTR[31:16] with F_PC=32'h102.
- REDIRECT in REQ1 of the fetch at 0x8: IADDR stays 0x8 through REQ2, its word is not queued, the next IADDR is the target, and F_VALID=0 until that capture.
- REDIRECT on the same edge as a handshake and a capture: the queue is empty after the edge and only target halfwords appear afterwards.
- RST pulsed mid-REQ2: IREQ=0, F_VALID=0 immediately. After release, the first IADDR = RESET_PC and the stale INSTR is never delivered.

Source files
------------

// File: rtl/thumb_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : thumb_fetch_pkg
// Brief    : Shared types and constants for the Thumb fetch front end.
// Revision : 1.0
// ============================================================================
package thumb_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ1 = 2'd1,
    ST_REQ2 = 2'd2
  } fetch_state_e;

  localparam logic IRW_READ = 1'b0;
  localparam int   HW_BYTES = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/thumb_fetch_unit_hw_queue.sv
`default_nettype none
// ============================================================================
// Module   : hw_queue
// Brief    : Circular halfword FIFO, up to two pushes and one pop per cycle.
// Revision : 1.0
// ============================================================================
module hw_queue
  import thumb_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_push_lo,
  input  logic                     i_push_hi,
  input  fetch_entry_t             i_lo_entry,
  input  fetch_entry_t             i_hi_entry,
  input  logic                     i_pop,
  output logic                     o_valid,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] w_hi_ptr;
  logic [AW:0]   r_count;
  logic [1:0]    w_push_n;
  logic          w_pop;

  assign w_push_n = {1'b0, i_push_lo} + {1'b0, i_push_hi};
  assign w_pop    = i_pop & o_valid;
  // The high halfword lands behind the low one only when the low one is pushed.
  assign w_hi_ptr = r_wr_ptr + AW'(i_push_lo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= r_count + (AW+1)'(w_push_n) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!i_clear) begin
      if (i_push_lo) r_mem[r_wr_ptr] <= i_lo_entry;
      if (i_push_hi) r_mem[w_hi_ptr] <= i_hi_entry;
    end
  end

  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/thumb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : thumb_fetch_unit
// Brief    : Thumb fetch front end: word requests, halfword split, redirect.
// Revision : 1.0
// ============================================================================
module thumb_fetch_unit
  import thumb_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IREQ,
  output logic [31:0] IADDR,
  output logic        IRW,
  input  logic [31:0] INSTR,
  output logic        F_VALID,
  output logic [15:0] F_INST,
  output logic [31:0] F_PC,
  input  logic        D_READY,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [AW:0] c_issue_max = (AW+1)'(DEPTH - 2);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_iaddr, w_iaddr_nxt;
  logic [31:0]  r_fetch_pc, w_fetch_pc_nxt;
  logic         r_skip_lo, w_skip_lo_nxt;
  logic         r_squash, w_squash_nxt;

  logic         w_q_valid;
  fetch_entry_t w_head;
  fetch_entry_t w_lo_entry;
  fetch_entry_t w_hi_entry;
  logic [AW:0]  w_count;
  logic [AW:0]  w_cnt_post;
  logic         w_pop;
  logic         w_capture;
  logic         w_push_lo;
  logic         w_push_hi;
  logic         w_issue;
  logic [31:0]  w_target;
  logic         w_unused_pc0;

  assign w_pop        = w_q_valid & D_READY;
  assign w_capture    = (r_state == ST_REQ2) & ~r_squash & ~REDIRECT;
  assign w_push_lo    = w_capture & ~r_skip_lo;
  assign w_push_hi    = w_capture;
  assign w_target     = {REDIRECT_PC[31:2], 2'b00};
  assign w_unused_pc0 = REDIRECT_PC[0];

  assign w_lo_entry = '{pc: r_iaddr, inst: INSTR[15:0]};
  assign w_hi_entry = '{pc: r_iaddr + 32'(HW_BYTES), inst: INSTR[31:16]};

  // Occupancy after this edge; next issue must leave room for a whole word.
  always_comb begin
    w_cnt_post = w_count;
    if (w_push_lo) w_cnt_post = w_cnt_post + (AW+1)'(1);
    if (w_push_hi) w_cnt_post = w_cnt_post + (AW+1)'(1);
    if (w_pop)     w_cnt_post = w_cnt_post - (AW+1)'(1);
    if (REDIRECT)  w_cnt_post = '0;
  end

  assign w_issue = (w_cnt_post <= c_issue_max);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_iaddr_nxt    = r_iaddr;
    w_fetch_pc_nxt = r_fetch_pc;
    w_skip_lo_nxt  = r_skip_lo;
    w_squash_nxt   = r_squash;
    IREQ           = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (REDIRECT) begin
          w_state_nxt    = ST_REQ1;
          w_iaddr_nxt    = w_target;
          w_fetch_pc_nxt = w_target + 32'd4;
          w_skip_lo_nxt  = REDIRECT_PC[1];
        end else if (w_issue) begin
          w_state_nxt    = ST_REQ1;
          w_iaddr_nxt    = r_fetch_pc;
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
      end
      ST_REQ1: begin
        w_state_nxt = ST_REQ2;
        // The request in flight keeps its address; only its data is dropped.
        if (REDIRECT) begin
          w_squash_nxt   = 1'b1;
          w_fetch_pc_nxt = w_target;
          w_skip_lo_nxt  = REDIRECT_PC[1];
        end
      end
      ST_REQ2: begin
        w_squash_nxt = 1'b0;
        if (REDIRECT) begin
          w_state_nxt    = ST_REQ1;
          w_iaddr_nxt    = w_target;
          w_fetch_pc_nxt = w_target + 32'd4;
          w_skip_lo_nxt  = REDIRECT_PC[1];
        end else begin
          if (w_capture) w_skip_lo_nxt = 1'b0;
          if (w_issue) begin
            w_state_nxt    = ST_REQ1;
            w_iaddr_nxt    = r_fetch_pc;
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_iaddr    <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_skip_lo  <= 1'b0;
      r_squash   <= 1'b0;
    end else begin
      r_iaddr    <= w_iaddr_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_skip_lo  <= w_skip_lo_nxt;
      r_squash   <= w_squash_nxt;
    end
  end

  hw_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (CLK),
    .rst        (RST),
    .i_clear    (REDIRECT),
    .i_push_lo  (w_push_lo),
    .i_push_hi  (w_push_hi),
    .i_lo_entry (w_lo_entry),
    .i_hi_entry (w_hi_entry),
    .i_pop      (w_pop),
    .o_valid    (w_q_valid),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  assign IADDR   = r_iaddr;
  assign IRW     = IRW_READ;
  assign F_VALID = w_q_valid;
  assign F_INST  = w_q_valid ? w_head.inst : 16'h0000;
  assign F_PC    = w_q_valid ? w_head.pc   : 32'h0000_0000;

endmodule
`default_nettype wire
